// File: rtl/bridge_master.sv
// bridge_master: replays each NoC request packet as one AXI-light transaction and returns the response packet.
// Optional AXI response watchdog enabled by defining BRIDGE_MASTER_TIMEOUT_EN.
module bridge_master #(
    parameter logic [5:0] ID      = 6'd0,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        noc_rx_valid,
    input  logic [31:0] noc_rx_data,
    output logic        noc_rx_ready,
    output logic        noc_tx_valid,
    output logic [31:0] noc_tx_data,
    input  logic        noc_tx_ready,
    output logic        m_awvalid,
    output logic [31:0] m_awaddr,
    input  logic        m_awready,
    output logic        m_wvalid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_wready,
    input  logic        m_bvalid,
    input  logic [1:0]  m_bresp,
    output logic        m_bready,
    output logic        m_arvalid,
    output logic [31:0] m_araddr,
    input  logic        m_arready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_rready
);
    typedef enum logic [3:0] {IDLE, DROP, RX_ADDR, RX_DATA, AW_W, B, AR, R, TX_HDR, TX_DATA} state_t;

    state_t      state;
    logic        is_write;
    logic [5:0]  src;
    logic [1:0]  drop_cnt;
    logic [31:0] rsp_data;
    logic        tmo;
    logic        rx_hs;
    logic [1:0]  rx_type;

    assign rx_hs   = noc_rx_valid && noc_rx_ready;
    assign rx_type = noc_rx_data[31:30];

    function automatic logic [31:0] rsp_hdr(input logic [1:0] st);
        return {is_write ? 2'b11 : 2'b10, src, ID, st, 16'h0};
    endfunction

`ifdef BRIDGE_MASTER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        waiting;

    assign waiting = state inside {AW_W, B, AR, R};
    assign tmo     = waiting && tmo_cnt == 32'(TIMEOUT - 1);

    // Watchdog: counts cycles spent waiting on the AXI slave, zero outside those states
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) tmo_cnt <= '0;
        else tmo_cnt <= waiting ? tmo_cnt + 32'd1 : '0;
    end
`else
    // No watchdog: the slave is waited on indefinitely (expression is constant false)
    assign tmo = TIMEOUT < 0;
`endif

    // Request/response sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= IDLE;
            is_write     <= 1'b0;
            src          <= '0;
            drop_cnt     <= '0;
            rsp_data     <= '0;
            noc_rx_ready <= 1'b0;
            noc_tx_valid <= 1'b0;
            noc_tx_data  <= '0;
            m_awvalid    <= 1'b0;
            m_awaddr     <= '0;
            m_wvalid     <= 1'b0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            m_bready     <= 1'b0;
            m_arvalid    <= 1'b0;
            m_araddr     <= '0;
            m_rready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    noc_rx_ready <= 1'b1;
                    if (rx_hs) begin
                        is_write <= rx_type[0];
                        src      <= noc_rx_data[23:18];
                        m_wstrb  <= noc_rx_data[3:0];
                        drop_cnt <= rx_type[0] ? 2'd2 : 2'd1;
                        if (!rx_type[1]) state <= (noc_rx_data[29:24] == ID) ? RX_ADDR : DROP;
                    end
                end
                DROP: if (rx_hs) begin
                    drop_cnt <= drop_cnt - 2'd1;
                    if (drop_cnt == 2'd1) state <= IDLE;
                end
                RX_ADDR: if (rx_hs) begin
                    m_awaddr <= noc_rx_data;
                    m_araddr <= noc_rx_data;
                    if (is_write) state <= RX_DATA;
                    else begin
                        noc_rx_ready <= 1'b0;
                        m_arvalid    <= 1'b1;
                        state        <= AR;
                    end
                end
                RX_DATA: if (rx_hs) begin
                    m_wdata      <= noc_rx_data;
                    noc_rx_ready <= 1'b0;
                    m_awvalid    <= 1'b1;
                    m_wvalid     <= 1'b1;
                    state        <= AW_W;
                end
                AW_W: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready) m_wvalid <= 1'b0;
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state    <= B;
                    end else if (tmo) begin
                        m_awvalid    <= 1'b0;
                        m_wvalid     <= 1'b0;
                        noc_tx_valid <= 1'b1;
                        noc_tx_data  <= rsp_hdr(2'b11);
                        state        <= TX_HDR;
                    end
                end
                B: if (m_bvalid || tmo) begin
                    m_bready     <= 1'b0;
                    noc_tx_valid <= 1'b1;
                    noc_tx_data  <= rsp_hdr(m_bvalid ? m_bresp : 2'b11);
                    state        <= TX_HDR;
                end
                AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= R;
                    end else if (tmo) begin
                        m_arvalid    <= 1'b0;
                        rsp_data     <= 32'hDEAD_BEEF;
                        noc_tx_valid <= 1'b1;
                        noc_tx_data  <= rsp_hdr(2'b11);
                        state        <= TX_HDR;
                    end
                end
                R: if (m_rvalid || tmo) begin
                    m_rready     <= 1'b0;
                    rsp_data     <= m_rvalid ? m_rdata : 32'hDEAD_BEEF;
                    noc_tx_valid <= 1'b1;
                    noc_tx_data  <= rsp_hdr(m_rvalid ? m_rresp : 2'b11);
                    state        <= TX_HDR;
                end
                TX_HDR: if (noc_tx_ready) begin
                    if (is_write) begin
                        noc_tx_valid <= 1'b0;
                        noc_rx_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        noc_tx_data <= rsp_data;
                        state       <= TX_DATA;
                    end
                end
                TX_DATA: if (noc_tx_ready) begin
                    noc_tx_valid <= 1'b0;
                    noc_rx_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bridge_master.sv
// tb_bridge_master: randomized self-checking bench for bridge_master against a packet-level reference model.
module tb_bridge_master;
    localparam logic [5:0] ID = 6'd3;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        noc_rx_valid = 1'b0;
    logic [31:0] noc_rx_data = '0;
    logic        noc_rx_ready;
    logic        noc_tx_valid;
    logic [31:0] noc_tx_data;
    logic        noc_tx_ready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [138:0] all_outs;

    int checks = 0, failures = 0, cyc = 0;
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, tx_stall = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    int aw_cyc = 0, w_cyc = 0, stall_cnt = 0, tx_first = 0;
    bit b_silent = 0, r_silent = 0, tx_seen = 0, hold_bad = 0, rx_bad = 0, prev_stall = 0;
    logic [31:0] prev_data = '0, rdata_v = '0;
    logic [1:0]  bresp_v = '0, rresp_v = '0;
    logic [31:0] aw_q[$], ar_q[$], tx_q[$];
    logic [35:0] w_q[$];

    bridge_master #(.ID(ID), .TIMEOUT(8)) dut (
        .clk(clk), .res_n(res_n),
        .noc_rx_valid(noc_rx_valid), .noc_rx_data(noc_rx_data), .noc_rx_ready(noc_rx_ready),
        .noc_tx_valid(noc_tx_valid), .noc_tx_data(noc_tx_data), .noc_tx_ready(noc_tx_ready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    assign all_outs = {noc_rx_ready, noc_tx_valid, noc_tx_data, m_awvalid, m_awaddr, m_wvalid,
                       m_wdata, m_wstrb, m_bready, m_arvalid, m_araddr, m_rready};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // AXI slave and NoC sink: readies/valids change on negedge, handshakes recorded for the coming posedge
    initial begin
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, noc_tx_ready} = '0;
        m_bresp = '0; m_rresp = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_awready = m_awvalid && aw_wait >= aw_delay;
            aw_wait   = m_awvalid ? aw_wait + 1 : 0;
            m_wready  = m_wvalid && w_wait >= w_delay;
            w_wait    = m_wvalid ? w_wait + 1 : 0;
            m_arready = m_arvalid && ar_wait >= ar_delay;
            ar_wait   = m_arvalid ? ar_wait + 1 : 0;
            m_bvalid  = m_bready && !b_silent && b_wait >= b_delay;
            b_wait    = m_bready ? b_wait + 1 : 0;
            m_bresp   = m_bvalid ? bresp_v : 2'b00;
            m_rvalid  = m_rready && !r_silent && r_wait >= r_delay;
            r_wait    = m_rready ? r_wait + 1 : 0;
            m_rdata   = m_rvalid ? rdata_v : 32'h0;
            m_rresp   = m_rvalid ? rresp_v : 2'b00;
            noc_tx_ready = !(noc_tx_valid && tx_stall > 0);
            if (noc_tx_valid && tx_stall > 0) tx_stall--;
            if (noc_tx_valid && prev_stall && noc_tx_data !== prev_data) hold_bad = 1;
            if (noc_tx_valid && noc_rx_ready) rx_bad = 1;
            if (noc_tx_valid && !noc_tx_ready) stall_cnt++;
            prev_stall = noc_tx_valid && !noc_tx_ready;
            prev_data  = noc_tx_data;
            if (noc_tx_valid && !tx_seen) begin tx_seen = 1; tx_first = cyc; end
            if (m_awvalid) aw_cyc++;
            if (m_wvalid) w_cyc++;
            if (m_awvalid && m_awready) aw_q.push_back(m_awaddr);
            if (m_wvalid && m_wready) w_q.push_back({m_wstrb, m_wdata});
            if (m_arvalid && m_arready) ar_q.push_back(m_araddr);
            if (noc_tx_valid && noc_tx_ready) tx_q.push_back(noc_tx_data);
        end
    end

    task automatic send_flit(input logic [31:0] d, output int hs_cyc);
        int n = 0;
        noc_rx_valid = 1'b1;
        noc_rx_data  = d;
        while (noc_rx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        hs_cyc = cyc;
        checks++;
        if (n >= 200) begin failures++; $display("FAIL rx_accept flit=%h ready=%b", d, noc_rx_ready); end
        @(negedge clk);
        noc_rx_valid = 1'b0;
        noc_rx_data  = '0;
    endtask

    // Reference model: a packet is served only if it is a READ/WRITE addressed to ID; one AXI op, then a response
    task automatic run_req(input logic [1:0] typ, input logic [5:0] dst, input logic [5:0] src,
                           input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdat, input logic [1:0] resp, input string tag,
                           output int lat);
        logic [31:0] exp_aw[$], exp_ar[$], exp_tx[$];
        logic [35:0] exp_w[$];
        bit acc;
        int n, c0;
        acc = typ < 2'd2 && dst == ID;
        if (acc && typ == 2'd1) begin
            exp_aw.push_back(addr);
            exp_w.push_back({strb, data});
            exp_tx.push_back({2'b11, src, ID, resp, 16'h0});
        end
        if (acc && typ == 2'd0) begin
            exp_ar.push_back(addr);
            exp_tx.push_back({2'b10, src, ID, resp, 16'h0});
            exp_tx.push_back(rdat);
        end
        bresp_v = resp; rresp_v = resp; rdata_v = rdat;
        aw_q.delete(); w_q.delete(); ar_q.delete(); tx_q.delete();
        tx_seen = 0; aw_cyc = 0; w_cyc = 0;
        send_flit({typ, dst, src, 2'b00, 12'h0, strb}, c0);
        if (typ < 2'd2) send_flit(addr, n);
        if (typ == 2'd1) send_flit(data, n);
        n = 0;
        while (tx_q.size() < exp_tx.size() && n < 300) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        lat = tx_seen ? tx_first - c0 : -1;
        checks++;
        if (aw_q.size() != exp_aw.size()) begin failures++; $display("FAIL %s aw_count got=%0d exp=%0d", tag, aw_q.size(), exp_aw.size()); end
        else foreach (exp_aw[i]) begin
            checks++;
            if (aw_q[i] !== exp_aw[i]) begin failures++; $display("FAIL %s awaddr got=%h exp=%h", tag, aw_q[i], exp_aw[i]); end
        end
        checks++;
        if (w_q.size() != exp_w.size()) begin failures++; $display("FAIL %s w_count got=%0d exp=%0d", tag, w_q.size(), exp_w.size()); end
        else foreach (exp_w[i]) begin
            checks++;
            if (w_q[i] !== exp_w[i]) begin failures++; $display("FAIL %s wstrb_wdata got=%h exp=%h", tag, w_q[i], exp_w[i]); end
        end
        checks++;
        if (ar_q.size() != exp_ar.size()) begin failures++; $display("FAIL %s ar_count got=%0d exp=%0d", tag, ar_q.size(), exp_ar.size()); end
        else foreach (exp_ar[i]) begin
            checks++;
            if (ar_q[i] !== exp_ar[i]) begin failures++; $display("FAIL %s araddr got=%h exp=%h", tag, ar_q[i], exp_ar[i]); end
        end
        checks++;
        if (tx_q.size() != exp_tx.size()) begin failures++; $display("FAIL %s tx_count got=%0d exp=%0d", tag, tx_q.size(), exp_tx.size()); end
        else foreach (exp_tx[i]) begin
            checks++;
            if (tx_q[i] !== exp_tx[i]) begin failures++; $display("FAIL %s tx_flit%0d got=%h exp=%h", tag, i, tx_q[i], exp_tx[i]); end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs); end
        res_n = 1'b1;
        @(negedge clk);
        checks++;
        if (noc_rx_ready !== 1'b1) begin failures++; $display("FAIL idle_rx_ready got=%b exp=1", noc_rx_ready); end
        checks++;
        if (noc_tx_valid !== 1'b0) begin failures++; $display("FAIL idle_tx_valid got=%b exp=0", noc_tx_valid); end
    endtask

    task automatic test_write();
        int lat;
        run_req(2'd1, ID, 6'd2, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 2'b00, "write", lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL write_latency got=%0d exp=5", lat); end
        checks++;
        if (tx_q.size() == 0 || tx_q[0] !== 32'hC20C_0000) begin failures++; $display("FAIL write_ack_hdr got=%h exp=c20c0000", tx_q.size() ? tx_q[0] : 32'hx); end
    endtask

    task automatic test_read();
        int lat;
        run_req(2'd0, ID, 6'd5, 4'h0, 32'h0000_0200, 32'h0, 32'h1234_5678, 2'b00, "read", lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
        checks++;
        if (tx_q.size() < 2 || tx_q[0] !== 32'h850C_0000 || tx_q[1] !== 32'h1234_5678) begin
            failures++; $display("FAIL read_resp got=%0d flits exp=850c0000,12345678", tx_q.size());
        end
    endtask

    task automatic test_aw_delay();
        int lat;
        aw_delay = 3;
        run_req(2'd1, ID, 6'd7, 4'h0, 32'h0000_0040, 32'h5555_AAAA, 32'h0, 2'b10, "aw_delay", lat);
        aw_delay = 0;
        checks++;
        if (aw_cyc !== 4) begin failures++; $display("FAIL awvalid_cycles got=%0d exp=4", aw_cyc); end
        checks++;
        if (w_cyc !== 1) begin failures++; $display("FAIL wvalid_cycles got=%0d exp=1", w_cyc); end
    endtask

    task automatic test_drop();
        int lat;
        run_req(2'd1, 6'd9, 6'd1, 4'h3, 32'h0000_0300, 32'h0BAD_0BAD, 32'h0, 2'b00, "drop_write", lat);
        run_req(2'd0, 6'd0, 6'd1, 4'h0, 32'h0000_0304, 32'h0, 32'h0, 2'b00, "drop_read", lat);
        run_req(2'd2, ID, 6'd1, 4'h0, 32'h0, 32'h0, 32'h0, 2'b00, "drop_rdresp", lat);
        run_req(2'd3, ID, 6'd1, 4'h0, 32'h0, 32'h0, 32'h0, 2'b00, "drop_wrack", lat);
        checks++;
        if (noc_rx_ready !== 1'b1) begin failures++; $display("FAIL drop_idle got=%b exp=1", noc_rx_ready); end
    endtask

    task automatic test_tx_stall();
        int lat;
        stall_cnt = 0; hold_bad = 0; tx_stall = 5;
        run_req(2'd0, ID, 6'd4, 4'h0, 32'h0000_0500, 32'h0, 32'h0F0F_1234, 2'b01, "tx_stall", lat);
        checks++;
        if (stall_cnt !== 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_cnt); end
        checks++;
        if (hold_bad !== 1'b0) begin failures++; $display("FAIL tx_hold_stable got=%b exp=0", hold_bad); end
        checks++;
        if (rx_bad !== 1'b0) begin failures++; $display("FAIL rx_ready_during_tx got=%b exp=0", rx_bad); end
    endtask

    task automatic test_back_to_back();
        int c0, c1, n;
        aw_q.delete(); ar_q.delete(); tx_q.delete(); tx_seen = 0;
        bresp_v = 2'b00; rresp_v = 2'b00; rdata_v = 32'h7777_8888;
        send_flit({2'b01, ID, 6'd10, 2'b00, 12'h0, 4'h5}, c0);
        send_flit(32'h0000_0600, n);
        send_flit(32'h1111_2222, n);
        send_flit({2'b00, ID, 6'd11, 2'b00, 16'h0}, c1);
        send_flit(32'h0000_0604, n);
        n = 0;
        while (tx_q.size() < 3 && n < 300) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++;
        if (c1 <= tx_first) begin failures++; $display("FAIL b2b_stall hdr2_cyc=%0d resp1_cyc=%0d", c1, tx_first); end
        checks++;
        if (tx_q.size() != 3) begin failures++; $display("FAIL b2b_tx_count got=%0d exp=3", tx_q.size()); end
        else begin
            checks++;
            if (tx_q[0] !== {2'b11, 6'd10, ID, 2'b00, 16'h0}) begin failures++; $display("FAIL b2b_ack got=%h", tx_q[0]); end
            checks++;
            if (tx_q[1] !== {2'b10, 6'd11, ID, 2'b00, 16'h0} || tx_q[2] !== 32'h7777_8888) begin
                failures++; $display("FAIL b2b_rdresp got=%h %h", tx_q[1], tx_q[2]);
            end
        end
        checks++;
        if (aw_q.size() != 1 || ar_q.size() != 1) begin failures++; $display("FAIL b2b_axi aw=%0d ar=%0d exp=1,1", aw_q.size(), ar_q.size()); end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0] typ;
        logic [5:0] dst;
        for (int k = 0; k < 25; k++) begin
            typ = ($urandom_range(0, 5) < 5) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            dst = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ID;
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3); tx_stall = $urandom_range(0, 3);
            run_req(typ, dst, 6'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 2'($urandom), "rnd", lat);
        end
        {aw_delay, w_delay, b_delay, ar_delay, r_delay, tx_stall} = '0;
    endtask

    task automatic test_reset_mid();
        int n, lat;
        ar_delay = 1000;
        send_flit({2'b00, ID, 6'd6, 2'b00, 16'h0}, n);
        send_flit(32'h0000_0700, n);
        @(negedge clk);
        checks++;
        if (m_arvalid !== 1'b1) begin failures++; $display("FAIL mid_arvalid got=%b exp=1", m_arvalid); end
        #2 res_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin failures++; $display("FAIL async_reset_outputs got=%h exp=0", all_outs); end
        @(negedge clk);
        ar_delay = 0;
        res_n = 1'b1;
        @(negedge clk);
        run_req(2'd1, ID, 6'd8, 4'h9, 32'h0000_0800, 32'hABCD_EF01, 32'h0, 2'b00, "after_reset", lat);
    endtask

`ifdef BRIDGE_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        r_silent = 1;
        run_req(2'd0, ID, 6'd12, 4'h0, 32'h0000_0900, 32'h0, 32'hDEAD_BEEF, 2'b11, "rd_timeout", lat);
        r_silent = 0;
        b_silent = 1;
        run_req(2'd1, ID, 6'd13, 4'hC, 32'h0000_0904, 32'h2468_ACE0, 32'h0, 2'b11, "wr_timeout", lat);
        b_silent = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_aw_delay();
        test_drop();
        test_tx_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef BRIDGE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
